// File: rtl/chart_drag_ctrl.sv
// Mouse-drag pan controller for the oscilloscope chart area.
// Tracks a left-button drag that starts inside a rectangular region and keeps
// one signed, saturated X/Y pan offset per channel. A double-click on the same
// channel zeroes that channel's offset. Outputs are sign-magnitude and registered.
module chart_drag_ctrl #(
  parameter int N_CH        = 4,
  parameter int POS_W       = 12,
  parameter int OFF_W       = 11,
  parameter int OFF_MAX     = 1023,
  parameter int X0          = 100,
  parameter int Y0          = 50,
  parameter int W           = 400,
  parameter int H           = 300,
  parameter int DCLK_CYCLES = 26_000_000
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      left_mouse,
  input  logic [POS_W-1:0]                          xpos,
  input  logic [POS_W-1:0]                          ypos,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
  output logic [OFF_W-1:0]                          x_off_mag,
  output logic                                      x_off_minus,
  output logic [OFF_W-1:0]                          y_off_mag,
  output logic                                      y_off_minus,
  output logic                                      dragging,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] drag_ch
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W = $clog2(DCLK_CYCLES + 1);
  localparam int D_W   = POS_W + 1;
  // Sum width covers the larger of delta and offset plus one growth bit, so a
  // full-screen move on a saturated offset never wraps before clamping.
  localparam int S_W   = ((D_W > OFF_W + 1) ? D_W : OFF_W + 1) + 1;

  localparam logic [POS_W-1:0]      X_LO  = POS_W'(X0);
  localparam logic [POS_W-1:0]      X_HI  = POS_W'(X0 + W - 1);
  localparam logic [POS_W-1:0]      Y_LO  = POS_W'(Y0);
  localparam logic [POS_W-1:0]      Y_HI  = POS_W'(Y0 + H - 1);
  localparam logic signed [S_W-1:0] LIM_P = S_W'(OFF_MAX);
  localparam logic signed [S_W-1:0] LIM_N = -S_W'(OFF_MAX);

  typedef enum logic [1:0] {S_IDLE, S_DRAG, S_ZERO} state_t;

  // Clamp a wide signed sum to [-OFF_MAX, +OFF_MAX].
  function automatic logic signed [OFF_W:0] sat_off(input logic signed [S_W-1:0] s);
    logic signed [S_W-1:0] c;
    if (s > LIM_P)      c = LIM_P;
    else if (s < LIM_N) c = LIM_N;
    else                c = s;
    return (OFF_W + 1)'(c);
  endfunction

  // Magnitude of a saturated offset; always fits OFF_W bits.
  function automatic logic [OFF_W-1:0] mag_of(input logic signed [OFF_W:0] v);
    logic signed [OFF_W:0] a;
    a = v[OFF_W] ? -v : v;
    return a[OFF_W-1:0];
  endfunction

  state_t                state_q, state_d;
  logic                  lm_q;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [CH_W-1:0]       drag_ch_q, drag_ch_d;
  logic [POS_W-1:0]      anc_x_q, anc_y_q;
  logic signed [OFF_W:0] base_x_q, base_y_q;
  logic signed [OFF_W:0] off_x_q [N_CH];
  logic signed [OFF_W:0] off_y_q [N_CH];

  logic [OFF_W-1:0]      x_mag_q, y_mag_q;
  logic                  x_minus_q, y_minus_q, dragging_q;

  logic                  press_w, rel_w, hit_w;
  logic                  start_drag, zero_en;
  logic signed [D_W-1:0] dx, dy;
  logic signed [S_W-1:0] sum_x, sum_y;
  logic signed [OFF_W:0] drag_x, drag_y, sel_x, sel_y;

  assign press_w = left_mouse & ~lm_q;
  assign rel_w   = ~left_mouse & lm_q;
  assign hit_w   = (xpos >= X_LO) && (xpos <= X_HI) && (ypos >= Y_LO) && (ypos <= Y_HI);

  // Drag arithmetic: new offset = sat(base + (pos - anchor)) per axis.
  always_comb begin
    dx     = $signed({1'b0, xpos}) - $signed({1'b0, anc_x_q});
    dy     = $signed({1'b0, ypos}) - $signed({1'b0, anc_y_q});
    sum_x  = S_W'(base_x_q) + S_W'(dx);
    sum_y  = S_W'(base_y_q) + S_W'(dy);
    drag_x = sat_off(sum_x);
    drag_y = sat_off(sum_y);
  end

  // Next-state, double-click timer and drag/zero strobes.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    drag_ch_d  = drag_ch_q;
    start_drag = 1'b0;
    zero_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
        if (press_w && hit_w) begin
          if ((tmr_q != '0) && (ch_sel == drag_ch_q)) begin
            state_d = S_ZERO;
            zero_en = 1'b1;
          end else begin
            state_d    = S_DRAG;
            start_drag = 1'b1;
            drag_ch_d  = ch_sel;
          end
        end
      end
      S_DRAG: begin
        if (rel_w) begin
          state_d = S_IDLE;
          tmr_d   = TMR_W'(DCLK_CYCLES);
        end
      end
      S_ZERO: begin
        // Clearing the timer here keeps a third quick click from zeroing again.
        if (rel_w) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; button history resets high so a held button cannot start a drag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      drag_ch_q <= '0;
      lm_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      drag_ch_q <= drag_ch_d;
      lm_q      <= left_mouse;
    end
  end

  // Anchor and base capture at drag start; only read while dragging.
  always_ff @(posedge clk) begin
    if (start_drag) begin
      anc_x_q  <= xpos;
      anc_y_q  <= ypos;
      base_x_q <= off_x_q[ch_sel];
      base_y_q <= off_y_q[ch_sel];
    end
  end

  // Per-channel offset storage: cleared on double-click, tracked while dragging.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        off_x_q[c] <= '0;
        off_y_q[c] <= '0;
      end
    end else if (zero_en) begin
      off_x_q[ch_sel] <= '0;
      off_y_q[ch_sel] <= '0;
    end else if (state_q == S_DRAG) begin
      off_x_q[drag_ch_q] <= drag_x;
      off_y_q[drag_ch_q] <= drag_y;
    end
  end

  // The dragged channel's storage is the live value, so selecting by ch_sel
  // covers both the live and the stored case.
  assign sel_x = off_x_q[ch_sel];
  assign sel_y = off_y_q[ch_sel];

  // Registered sign-magnitude outputs and drag status.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_mag_q    <= '0;
      x_minus_q  <= 1'b0;
      y_mag_q    <= '0;
      y_minus_q  <= 1'b0;
      dragging_q <= 1'b0;
    end else begin
      x_mag_q    <= mag_of(sel_x);
      x_minus_q  <= sel_x[OFF_W];
      y_mag_q    <= mag_of(sel_y);
      y_minus_q  <= sel_y[OFF_W];
      dragging_q <= (state_d == S_DRAG);
    end
  end

  assign x_off_mag   = x_mag_q;
  assign x_off_minus = x_minus_q;
  assign y_off_mag   = y_mag_q;
  assign y_off_minus = y_minus_q;
  assign dragging    = dragging_q;
  assign drag_ch     = drag_ch_q;

endmodule

// File: tb/tb_chart_drag_ctrl.sv
// Directed bench for chart_drag_ctrl: drag, saturation, region edges,
// channel isolation, double-click zeroing and reset mid-drag.
module tb_chart_drag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        left_mouse;
  logic [11:0] xpos, ypos;
  logic [1:0]  ch_sel;
  logic [10:0] x_off_mag, y_off_mag;
  logic        x_off_minus, y_off_minus, dragging;
  logic [1:0]  drag_ch;

  int checks   = 0;
  int failures = 0;

  chart_drag_ctrl #(
    .N_CH(4), .POS_W(12), .OFF_W(11), .OFF_MAX(500),
    .X0(100), .Y0(50), .W(400), .H(300), .DCLK_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .left_mouse(left_mouse),
    .xpos(xpos), .ypos(ypos), .ch_sel(ch_sel),
    .x_off_mag(x_off_mag), .x_off_minus(x_off_minus),
    .y_off_mag(y_off_mag), .y_off_minus(y_off_minus),
    .dragging(dragging), .drag_ch(drag_ch)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pos(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
  endtask

  // Expected {x_mag, x_minus, y_mag, y_minus} for signed offsets x, y.
  function automatic logic [23:0] so(input int x, input int y);
    int ax, ay;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    return {11'(ax), (x < 0), 11'(ay), (y < 0)};
  endfunction

  function automatic logic [23:0] got_off();
    return {x_off_mag, x_off_minus, y_off_mag, y_off_minus};
  endfunction

  // Full drag on a channel, then enough idle cycles to expire the double-click window.
  task automatic do_drag(input int ch, input int x0, input int y0, input int x1, input int y1);
    ch_sel = 2'(ch);
    set_pos(x0, y0);
    left_mouse = 1'b1;
    tick();
    set_pos(x1, y1);
    tick(2);
    left_mouse = 1'b0;
    tick(11);
  endtask

  task automatic test_reset();
    rst = 1'b1; left_mouse = 1'b0; ch_sel = 2'd0; set_pos(0, 0);
    tick(2);
    checks++; if (got_off() !== so(0, 0)) begin failures++;
      $display("FAIL reset_off got=%h exp=%h", got_off(), so(0, 0)); end
    checks++; if (dragging !== 1'b0) begin failures++;
      $display("FAIL reset_dragging got=%b exp=0", dragging); end
    checks++; if (drag_ch !== 2'd0) begin failures++;
      $display("FAIL reset_drag_ch got=%0d exp=0", drag_ch); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_drag();
    ch_sel = 2'd1; set_pos(200, 100); left_mouse = 1'b1;
    tick();
    checks++; if (dragging !== 1'b1) begin failures++;
      $display("FAIL basic_dragging_on got=%b exp=1", dragging); end
    checks++; if (drag_ch !== 2'd1) begin failures++;
      $display("FAIL basic_drag_ch got=%0d exp=1", drag_ch); end
    set_pos(230, 80);
    tick(2);
    checks++; if (got_off() !== so(30, -20)) begin failures++;
      $display("FAIL basic_off got=%h exp=%h", got_off(), so(30, -20)); end
    left_mouse = 1'b0;
    tick();
    checks++; if (dragging !== 1'b0) begin failures++;
      $display("FAIL basic_dragging_off got=%b exp=0", dragging); end
    tick(11);
    checks++; if (got_off() !== so(30, -20)) begin failures++;
      $display("FAIL basic_hold got=%h exp=%h", got_off(), so(30, -20)); end
  endtask

  task automatic test_accumulate();
    do_drag(1, 150, 60, 490, 60);
    checks++; if (got_off() !== so(370, -20)) begin failures++;
      $display("FAIL acc_370 got=%h exp=%h", got_off(), so(370, -20)); end
    do_drag(1, 150, 60, 350, 60);
    checks++; if (got_off() !== so(500, -20)) begin failures++;
      $display("FAIL acc_sat_pos got=%h exp=%h", got_off(), so(500, -20)); end
    do_drag(1, 499, 60, 0, 60);
    checks++; if (got_off() !== so(1, -20)) begin failures++;
      $display("FAIL acc_left1 got=%h exp=%h", got_off(), so(1, -20)); end
    do_drag(1, 499, 60, 0, 60);
    checks++; if (got_off() !== so(-498, -20)) begin failures++;
      $display("FAIL acc_left2 got=%h exp=%h", got_off(), so(-498, -20)); end
    do_drag(1, 499, 60, 0, 60);
    checks++; if (got_off() !== so(-500, -20)) begin failures++;
      $display("FAIL acc_sat_neg got=%h exp=%h", got_off(), so(-500, -20)); end
  endtask

  task automatic test_edge_rules();
    ch_sel = 2'd1; set_pos(50, 50); left_mouse = 1'b1;
    tick();
    set_pos(200, 100);
    tick(3);
    checks++; if (dragging !== 1'b0) begin failures++;
      $display("FAIL edge_outside_dragging got=%b exp=0", dragging); end
    checks++; if (got_off() !== so(-500, -20)) begin failures++;
      $display("FAIL edge_outside_off got=%h exp=%h", got_off(), so(-500, -20)); end
    left_mouse = 1'b0;
    tick();
    ch_sel = 2'd3; set_pos(100, 50); left_mouse = 1'b1;
    tick();
    checks++; if (dragging !== 1'b1) begin failures++;
      $display("FAIL edge_corner_dragging got=%b exp=1", dragging); end
    checks++; if (drag_ch !== 2'd3) begin failures++;
      $display("FAIL edge_corner_drag_ch got=%0d exp=3", drag_ch); end
    left_mouse = 1'b0;
    tick(11);
    set_pos(500, 50); left_mouse = 1'b1;
    tick(2);
    checks++; if (dragging !== 1'b0) begin failures++;
      $display("FAIL edge_right_dragging got=%b exp=0", dragging); end
    left_mouse = 1'b0;
    tick(2);
  endtask

  task automatic test_channel_isolation();
    ch_sel = 2'd2; set_pos(200, 200); left_mouse = 1'b1;
    tick();
    set_pos(210, 210);
    tick(2);
    checks++; if (got_off() !== so(10, 10)) begin failures++;
      $display("FAIL iso_live got=%h exp=%h", got_off(), so(10, 10)); end
    ch_sel = 2'd0;
    tick();
    checks++; if (got_off() !== so(0, 0)) begin failures++;
      $display("FAIL iso_ch0 got=%h exp=%h", got_off(), so(0, 0)); end
    checks++; if (dragging !== 1'b1 || drag_ch !== 2'd2) begin failures++;
      $display("FAIL iso_still_drag got=%b/%0d exp=1/2", dragging, drag_ch); end
    left_mouse = 1'b0;
    tick();
    ch_sel = 2'd2;
    tick();
    checks++; if (got_off() !== so(10, 10)) begin failures++;
      $display("FAIL iso_ch2_after got=%h exp=%h", got_off(), so(10, 10)); end
    tick(11);
  endtask

  task automatic test_double_click();
    ch_sel = 2'd2; set_pos(200, 200); left_mouse = 1'b1;
    tick();
    set_pos(205, 195);
    tick(2);
    checks++; if (got_off() !== so(15, 5)) begin failures++;
      $display("FAIL dclk_pre got=%h exp=%h", got_off(), so(15, 5)); end
    left_mouse = 1'b0;
    tick(2);
    // Press outside the region inside the window must not consume it.
    set_pos(50, 50); left_mouse = 1'b1;
    tick();
    left_mouse = 1'b0;
    tick();
    set_pos(200, 200); left_mouse = 1'b1;
    tick();
    checks++; if (dragging !== 1'b0) begin failures++;
      $display("FAIL dclk_zero_dragging got=%b exp=0", dragging); end
    tick();
    checks++; if (got_off() !== so(0, 0)) begin failures++;
      $display("FAIL dclk_zero_off got=%h exp=%h", got_off(), so(0, 0)); end
    left_mouse = 1'b0;
    tick();
    left_mouse = 1'b1;
    tick();
    checks++; if (dragging !== 1'b1) begin failures++;
      $display("FAIL dclk_third_dragging got=%b exp=1", dragging); end
    set_pos(203, 200);
    tick(2);
    checks++; if (got_off() !== so(3, 0)) begin failures++;
      $display("FAIL dclk_third_off got=%h exp=%h", got_off(), so(3, 0)); end
    left_mouse = 1'b0;
    tick();
    tick(8);
    set_pos(200, 200); left_mouse = 1'b1;
    tick();
    checks++; if (dragging !== 1'b1) begin failures++;
      $display("FAIL dclk_late_dragging got=%b exp=1", dragging); end
    set_pos(201, 200);
    tick(2);
    checks++; if (got_off() !== so(4, 0)) begin failures++;
      $display("FAIL dclk_late_off got=%h exp=%h", got_off(), so(4, 0)); end
    left_mouse = 1'b0;
    tick(11);
  endtask

  task automatic test_reset_mid_drag();
    ch_sel = 2'd2; set_pos(200, 200); left_mouse = 1'b1;
    tick();
    set_pos(220, 220);
    tick(2);
    checks++; if (got_off() !== so(24, 20)) begin failures++;
      $display("FAIL rstmid_pre got=%h exp=%h", got_off(), so(24, 20)); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (got_off() !== so(0, 0) || dragging !== 1'b0 || drag_ch !== 2'd0) begin failures++;
      $display("FAIL rstmid_clear got=%h/%b/%0d exp=%h/0/0", got_off(), dragging, drag_ch, so(0, 0)); end
    set_pos(300, 300);
    tick(3);
    checks++; if (dragging !== 1'b0 || got_off() !== so(0, 0)) begin failures++;
      $display("FAIL rstmid_held got=%b/%h exp=0/%h", dragging, got_off(), so(0, 0)); end
    ch_sel = 2'd1;
    tick();
    checks++; if (got_off() !== so(0, 0)) begin failures++;
      $display("FAIL rstmid_ch1 got=%h exp=%h", got_off(), so(0, 0)); end
    left_mouse = 1'b0;
    tick();
    left_mouse = 1'b1;
    tick();
    checks++; if (dragging !== 1'b1) begin failures++;
      $display("FAIL rstmid_repress got=%b exp=1", dragging); end
    left_mouse = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_basic_drag();
    test_accumulate();
    test_edge_rules();
    test_channel_isolation();
    test_double_click();
    test_reset_mid_drag();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
